dcache_sram_nway: RTL and testbench

DCACHE_SRAM_NWAY -- requirements
Module: dcache_sram_nway

---
 rtl/dcache_sram_nway.sv | 178 +++++++++++++++++
 tb/tb_dcache_sram_nway.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_sram_nway.sv
// N-way set-associative cache storage with age-based LRU replacement,
// a one-cycle registered response path and a set-by-set flush sequencer.
module dcache_sram_nway #(
   parameter int SETS   = 16,
   parameter int WAYS   = 2,
   parameter int TAG_W  = 23,
   parameter int LINE_W = 256,
   localparam int IDX_W = $clog2(SETS),
   localparam int WAY_W = $clog2(WAYS)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              req_i,
   input  logic [1:0]        op_i,
   input  logic [IDX_W-1:0]  idx_i,
   input  logic [TAG_W-1:0]  tag_i,
   input  logic [LINE_W-1:0] data_i,
   input  logic              dirty_i,
   input  logic              flush_i,
   output logic              ready_o,
   output logic              busy_o,
   output logic              rsp_valid_o,
   output logic              hit_o,
   output logic [WAY_W-1:0]  hit_way_o,
   output logic [LINE_W-1:0] data_o,
   output logic              victim_valid_o,
   output logic              victim_dirty_o,
   output logic [TAG_W-1:0]  victim_tag_o,
   output logic [LINE_W-1:0] victim_data_o,
   output logic [WAY_W-1:0]  victim_way_o
);

   localparam logic [1:0] OP_LOOKUP = 2'b00;
   localparam logic [1:0] OP_WRITE  = 2'b01;
   localparam logic [1:0] OP_FILL   = 2'b10;

   typedef enum logic {S_IDLE, S_FLUSH} state_t;
   state_t r_state, w_state_nxt;

   logic [WAYS-1:0]   r_valid [SETS];
   logic [WAYS-1:0]   r_dirty [SETS];
   logic [WAY_W-1:0]  r_age   [SETS][WAYS];
   logic [TAG_W-1:0]  r_tag   [SETS][WAYS];
   logic [LINE_W-1:0] r_line  [SETS][WAYS];
   logic [IDX_W-1:0]  r_fcnt;

   logic              r_rsp_valid, r_hit, r_vic_valid, r_vic_dirty;
   logic [WAY_W-1:0]  r_hit_way, r_vic_way;
   logic [LINE_W-1:0] r_data, r_vic_data;
   logic [TAG_W-1:0]  r_vic_tag;

   logic              w_acc, w_hit, w_has_inv, w_do_mru, w_wr_line, w_wr_tag;
   logic [WAY_W-1:0]  w_hit_way, w_vic_way, w_mru_way;

   // Victim: lowest invalid way first, otherwise the oldest (age == WAYS-1).
   always_comb begin
      w_hit     = 1'b0;
      w_hit_way = '0;
      w_has_inv = 1'b0;
      w_vic_way = '0;
      for (int w = 0; w < WAYS; w++)
         if (r_valid[idx_i][w] && r_tag[idx_i][w] == tag_i) begin
            w_hit     = 1'b1;
            w_hit_way = WAY_W'(w);
         end
      for (int w = WAYS-1; w >= 0; w--)
         if (!r_valid[idx_i][w]) begin
            w_has_inv = 1'b1;
            w_vic_way = WAY_W'(w);
         end
      if (!w_has_inv)
         for (int w = 0; w < WAYS; w++)
            if (r_age[idx_i][w] == WAY_W'(WAYS-1)) w_vic_way = WAY_W'(w);
   end

   assign w_acc     = (r_state == S_IDLE) && req_i;
   assign w_wr_tag  = w_acc && (op_i == OP_FILL);
   assign w_wr_line = w_acc && ((op_i == OP_WRITE && w_hit) || op_i == OP_FILL);
   assign w_do_mru  = w_acc && ((op_i == OP_LOOKUP && w_hit) || w_wr_line);
   assign w_mru_way = (op_i == OP_FILL && !w_hit) ? w_vic_way : w_hit_way;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (flush_i) w_state_nxt = S_FLUSH;
         S_FLUSH: if (r_fcnt == IDX_W'(SETS-1)) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Metadata; r_fcnt wraps back to 0 on the last flush cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_fcnt <= '0;
         for (int s = 0; s < SETS; s++) begin
            r_valid[s] <= '0;
            r_dirty[s] <= '0;
            for (int w = 0; w < WAYS; w++) r_age[s][w] <= WAY_W'(w);
         end
      end else if (r_state == S_FLUSH) begin
         r_valid[r_fcnt] <= '0;
         r_dirty[r_fcnt] <= '0;
         for (int w = 0; w < WAYS; w++) r_age[r_fcnt][w] <= WAY_W'(w);
         r_fcnt <= r_fcnt + IDX_W'(1);
      end else begin
         if (w_wr_tag) begin
            r_valid[idx_i][w_mru_way] <= 1'b1;
            r_dirty[idx_i][w_mru_way] <= dirty_i;
         end else if (w_wr_line) begin
            r_dirty[idx_i][w_mru_way] <= 1'b1;
         end
         if (w_do_mru)
            for (int w = 0; w < WAYS; w++)
               if (WAY_W'(w) == w_mru_way)
                  r_age[idx_i][w] <= '0;
               else if (r_age[idx_i][w] < r_age[idx_i][w_mru_way])
                  r_age[idx_i][w] <= r_age[idx_i][w] + WAY_W'(1);
      end
   end

   // Tag and line arrays carry no reset.
   always_ff @(posedge clk_i) begin
      if (w_wr_tag)  r_tag[idx_i][w_mru_way]  <= tag_i;
      if (w_wr_line) r_line[idx_i][w_mru_way] <= data_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rsp_valid <= 1'b0;
         r_hit       <= 1'b0;
         r_hit_way   <= '0;
         r_data      <= '0;
         r_vic_valid <= 1'b0;
         r_vic_dirty <= 1'b0;
         r_vic_tag   <= '0;
         r_vic_data  <= '0;
         r_vic_way   <= '0;
      end else begin
         r_rsp_valid <= w_acc;
         if (w_acc) begin
            r_hit     <= w_hit;
            r_hit_way <= w_hit ? w_hit_way : '0;
            r_data    <= w_hit ? r_line[idx_i][w_hit_way] : '0;
            if (op_i == OP_FILL && w_hit) begin
               r_vic_valid <= 1'b0;
               r_vic_dirty <= 1'b0;
               r_vic_tag   <= '0;
               r_vic_data  <= '0;
               r_vic_way   <= '0;
            end else begin
               r_vic_valid <= r_valid[idx_i][w_vic_way];
               r_vic_dirty <= r_dirty[idx_i][w_vic_way];
               r_vic_tag   <= r_tag[idx_i][w_vic_way];
               r_vic_data  <= r_line[idx_i][w_vic_way];
               r_vic_way   <= w_vic_way;
            end
         end
      end
   end

   assign ready_o        = (r_state == S_IDLE);
   assign busy_o         = (r_state == S_FLUSH);
   assign rsp_valid_o    = r_rsp_valid;
   assign hit_o          = r_hit;
   assign hit_way_o      = r_hit_way;
   assign data_o         = r_data;
   assign victim_valid_o = r_vic_valid;
   assign victim_dirty_o = r_vic_dirty;
   assign victim_tag_o   = r_vic_tag;
   assign victim_data_o  = r_vic_data;
   assign victim_way_o   = r_vic_way;

endmodule

// File: tb/tb_dcache_sram_nway.sv
// Scoreboard bench for dcache_sram_nway: requests are predicted by a
// timestamp-LRU cache model; a negedge monitor checks each response.
module tb_dcache_sram_nway;
   localparam int SETS   = 16;
   localparam int WAYS   = 2;
   localparam int TAG_W  = 23;
   localparam int LINE_W = 256;
   localparam int IDX_W  = $clog2(SETS);
   localparam int WAY_W  = $clog2(WAYS);

   logic              clk_i = 1'b0;
   logic              rst_ni = 1'b0;
   logic              req_i = 1'b0;
   logic [1:0]        op_i = '0;
   logic [IDX_W-1:0]  idx_i = '0;
   logic [TAG_W-1:0]  tag_i = '0;
   logic [LINE_W-1:0] data_i = '0;
   logic              dirty_i = 1'b0;
   logic              flush_i = 1'b0;
   logic              ready_o, busy_o, rsp_valid_o, hit_o;
   logic [WAY_W-1:0]  hit_way_o, victim_way_o;
   logic [LINE_W-1:0] data_o, victim_data_o;
   logic              victim_valid_o, victim_dirty_o;
   logic [TAG_W-1:0]  victim_tag_o;

   dcache_sram_nway #(.SETS(SETS), .WAYS(WAYS), .TAG_W(TAG_W), .LINE_W(LINE_W)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .op_i(op_i), .idx_i(idx_i),
      .tag_i(tag_i), .data_i(data_i), .dirty_i(dirty_i), .flush_i(flush_i),
      .ready_o(ready_o), .busy_o(busy_o), .rsp_valid_o(rsp_valid_o), .hit_o(hit_o),
      .hit_way_o(hit_way_o), .data_o(data_o), .victim_valid_o(victim_valid_o),
      .victim_dirty_o(victim_dirty_o), .victim_tag_o(victim_tag_o),
      .victim_data_o(victim_data_o), .victim_way_o(victim_way_o));

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic              chk_hit, chk_data, chk_vic, chk_vway;
      logic              hit;
      logic [WAY_W-1:0]  hw;
      logic [LINE_W-1:0] data;
      logic              vv, vd;
      logic [TAG_W-1:0]  vtag;
      logic [LINE_W-1:0] vdata;
      logic [WAY_W-1:0]  vway;
   } exp_t;

   exp_t q[$];
   int n_chk = 0;
   int n_fail = 0;

   // Reference model: recency kept as a last-use timestamp per way.
   bit                m_valid [SETS][WAYS];
   bit                m_dirty [SETS][WAYS];
   logic [TAG_W-1:0]  m_tag   [SETS][WAYS];
   logic [LINE_W-1:0] m_line  [SETS][WAYS];
   int                m_ts    [SETS][WAYS];
   int                m_time = 0;

   function automatic void m_clear_all();
      for (int s = 0; s < SETS; s++)
         for (int w = 0; w < WAYS; w++) begin
            m_valid[s][w] = 0;
            m_dirty[s][w] = 0;
            m_ts[s][w]    = -w;
         end
   endfunction

   function automatic logic [LINE_W-1:0] rand_line();
      logic [LINE_W-1:0] l;
      for (int i = 0; i < LINE_W/32; i++) l[i*32 +: 32] = $urandom;
      return l;
   endfunction

   task automatic chk(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic issue(input logic [1:0] op, input int idx, input int tag,
                        input logic [LINE_W-1:0] data, input logic dirty, input logic flush);
      exp_t e;
      int hw, vw;
      @(negedge clk_i);
      req_i = 1'b1; op_i = op; idx_i = IDX_W'(idx); tag_i = TAG_W'(tag);
      data_i = data; dirty_i = dirty; flush_i = flush;
      hw = -1;
      for (int w = 0; w < WAYS; w++)
         if (m_valid[idx][w] && m_tag[idx][w] == TAG_W'(tag)) hw = w;
      vw = -1;
      for (int w = WAYS-1; w >= 0; w--) if (!m_valid[idx][w]) vw = w;
      if (vw < 0) begin
         vw = 0;
         for (int w = 1; w < WAYS; w++) if (m_ts[idx][w] < m_ts[idx][vw]) vw = w;
      end
      e = '0;
      e.hit = (hw >= 0);
      if (hw >= 0) e.hw = WAY_W'(hw);
      if (op == 2'b00 || op == 2'b10) begin
         if (!(op == 2'b10 && hw >= 0)) begin
            e.chk_vway = 1'b1;
            e.vway = WAY_W'(vw);
            e.vv = m_valid[idx][vw];
            if (e.vv) begin
               e.vd = m_dirty[idx][vw];
               e.vtag = m_tag[idx][vw];
               e.vdata = m_line[idx][vw];
            end
         end
      end
      case (op)
         2'b00: begin
            e.chk_hit = 1'b1;
            if (hw >= 0) begin
               e.chk_data = 1'b1;
               e.data = m_line[idx][hw];
               m_ts[idx][hw] = ++m_time;
            end else e.chk_vic = 1'b1;
         end
         2'b01: begin
            e.chk_hit = 1'b1;
            if (hw >= 0) begin
               m_line[idx][hw] = data;
               m_dirty[idx][hw] = 1;
               m_ts[idx][hw] = ++m_time;
            end
         end
         2'b10: begin
            int t;
            e.chk_vic = 1'b1;
            t = (hw >= 0) ? hw : vw;
            m_valid[idx][t] = 1;
            m_dirty[idx][t] = dirty;
            m_tag[idx][t] = TAG_W'(tag);
            m_line[idx][t] = data;
            m_ts[idx][t] = ++m_time;
         end
         default: ;
      endcase
      q.push_back(e);
      if (flush) m_clear_all();
   endtask

   task automatic idle();
      @(negedge clk_i);
      req_i = 1'b0; flush_i = 1'b0;
   endtask

   always @(negedge clk_i) begin
      if (rst_ni && rsp_valid_o) begin
         if (q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_rsp: got rsp_valid_o=1 expected no response (t=%0t)", $time);
         end else begin
            exp_t e;
            e = q.pop_front();
            if (e.chk_hit) begin
               chk("hit", LINE_W'(hit_o), LINE_W'(e.hit));
               if (e.hit) chk("hit_way", LINE_W'(hit_way_o), LINE_W'(e.hw));
            end
            if (e.chk_data) chk("data", data_o, e.data);
            if (e.chk_vic) begin
               chk("victim_valid", LINE_W'(victim_valid_o), LINE_W'(e.vv));
               chk("victim_dirty", LINE_W'(victim_dirty_o), LINE_W'(e.vd));
               if (e.vv) begin
                  chk("victim_tag", LINE_W'(victim_tag_o), LINE_W'(e.vtag));
                  chk("victim_data", victim_data_o, e.vdata);
               end
               if (e.chk_vway) chk("victim_way", LINE_W'(victim_way_o), LINE_W'(e.vway));
            end
         end
      end
   end

   task automatic reset_checks();
      chk("rst_ready", LINE_W'(ready_o), LINE_W'(1));
      chk("rst_busy", LINE_W'(busy_o), '0);
      chk("rst_rsp_valid", LINE_W'(rsp_valid_o), '0);
      chk("rst_hit", LINE_W'(hit_o), '0);
      chk("rst_hit_way", LINE_W'(hit_way_o), '0);
      chk("rst_data", data_o, '0);
      chk("rst_victim_valid", LINE_W'(victim_valid_o), '0);
      chk("rst_victim_tag", LINE_W'(victim_tag_o), '0);
      chk("rst_victim_data", victim_data_o, '0);
   endtask

   initial begin
      logic [LINE_W-1:0] a, b;
      m_clear_all();
      #12;
      reset_checks();
      @(negedge clk_i);
      rst_ni = 1'b1;

      a = rand_line();
      b = rand_line();
      issue(2'b00, 3, 5, '0, 0, 0);          // cold miss, victim way 0 invalid
      issue(2'b10, 3, 5, a, 0, 0);
      issue(2'b00, 3, 5, '0, 0, 0);          // hit way 0, data a
      issue(2'b10, 0, 1, rand_line(), 0, 0);
      issue(2'b10, 0, 2, rand_line(), 0, 0);
      issue(2'b00, 0, 1, '0, 0, 0);
      issue(2'b10, 0, 3, rand_line(), 0, 0); // evicts tag 2 from way 1
      issue(2'b01, 0, 1, b, 0, 0);
      issue(2'b00, 0, 3, '0, 0, 0);
      issue(2'b10, 0, 4, rand_line(), 0, 0); // evicts dirty tag 1 with data b
      issue(2'b01, 0, 9, rand_line(), 0, 0); // write miss
      idle();

      for (int i = 0; i < 300; i++) begin
         int r;
         logic [1:0] op;
         r = $urandom_range(0, 9);
         op = (r < 4) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
         issue(op, ($urandom_range(0, 7) == 0) ? $urandom_range(0, SETS-1) : $urandom_range(0, 3),
               $urandom_range(1, 6), rand_line(), 1'($urandom_range(0, 1)), 0);
      end
      idle();

      issue(2'b00, 3, 5, '0, 0, 1);          // request and flush together
      for (int i = 0; i < SETS; i++) begin
         @(negedge clk_i);
         req_i = 1'b1; flush_i = 1'b1; op_i = 2'b10;
         chk("flush_busy", LINE_W'(busy_o), LINE_W'(1));
         chk("flush_ready", LINE_W'(ready_o), '0);
      end
      @(negedge clk_i);
      chk("flush_done_busy", LINE_W'(busy_o), '0);
      chk("flush_done_ready", LINE_W'(ready_o), LINE_W'(1));
      req_i = 1'b0; flush_i = 1'b0;
      for (int s = 0; s < SETS; s++) issue(2'b00, s, $urandom_range(1, 6), '0, 0, 0);
      idle();

      for (int i = 0; i < 8; i++) issue(2'b10, i % 4, $urandom_range(1, 6), rand_line(), 1, 0);
      idle();
      @(negedge clk_i);
      flush_i = 1'b1;
      @(negedge clk_i);
      flush_i = 1'b0;
      chk("mid_flush_busy", LINE_W'(busy_o), LINE_W'(1));
      repeat (3) @(negedge clk_i);
      rst_ni = 1'b0;
      #1;
      chk("rst_abort_busy", LINE_W'(busy_o), '0);
      chk("rst_abort_ready", LINE_W'(ready_o), LINE_W'(1));
      chk("rst_abort_rsp", LINE_W'(rsp_valid_o), '0);
      chk("rst_abort_vvalid", LINE_W'(victim_valid_o), '0);
      m_clear_all();
      @(negedge clk_i);
      rst_ni = 1'b1;
      for (int s = 0; s < 4; s++)
         for (int t = 1; t <= 6; t++) issue(2'b00, s, t, '0, 0, 0);
      idle();

      repeat (3) @(negedge clk_i);
      chk("scoreboard_drained", LINE_W'(q.size()), '0);
      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end
endmodule
